qeciphy_tx_scheduler: RTL and testbench

Per-slot arbiter that shares the QECIPHY TX frame slot between training patterns, control frames, periodic heartbeats and user data. It sits between the link controller's `tx_link_enable`/`tx_data_enable` outputs and the TX encoder/serializer. Its heartbeat frames carry the local RX-ready flag, and the remote side consumes that flag as `remote_rx_ready`.

---
 rtl/qeciphy_tx_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_qeciphy_tx_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_tx_scheduler.sv
// qeciphy_tx_scheduler
// Shares the single QECIPHY TX frame slot between training patterns, control
// frames, periodic heartbeats and user data. The link mode is decoded every
// cycle from the link controller's enables. A new frame is chosen only when
// the output register is free or is being consumed downstream.
//
// Parameter constraints: DATA_W >= 16, HB_INTERVAL >= 4, and ctrl_code_i must
// be non-zero because code 0x00 identifies a heartbeat.
module qeciphy_tx_scheduler #(
   parameter int unsigned DATA_W        = 64,
   parameter int unsigned HB_INTERVAL   = 1024,
   parameter logic [63:0] TRAIN_PATTERN = 64'hBC50_BC50_BC50_BC50
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              tx_link_enable_i,
   input  logic              tx_data_enable_i,
   input  logic              rx_ready_i,
   input  logic [DATA_W-1:0] user_tdata_i,
   input  logic              user_tvalid_i,
   output logic              user_tready_o,
   input  logic              ctrl_req_i,
   input  logic [7:0]        ctrl_code_i,
   output logic              ctrl_ack_o,
   output logic [DATA_W-1:0] frame_data_o,
   output logic [1:0]        frame_type_o,
   output logic              frame_valid_o,
   input  logic              frame_ready_i
);

   localparam int unsigned       HB_CNT_W   = (HB_INTERVAL > 1) ? $clog2(HB_INTERVAL) : 1;
   localparam logic [HB_CNT_W-1:0] HB_LAST  = HB_CNT_W'(HB_INTERVAL - 1);
   localparam logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(TRAIN_PATTERN);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_TRAIN = 2'd1,
      MODE_DATA  = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      FT_IDLE  = 2'b00,
      FT_TRAIN = 2'b01,
      FT_CTRL  = 2'b10,
      FT_DATA  = 2'b11
   } frame_type_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   mode_e                mode_q;
   mode_e                mode_d;
   logic [HB_CNT_W-1:0]  hb_cnt_q;
   logic                 hb_pending_q;
   logic                 last_ctrl_q;
   logic [DATA_W-1:0]    frame_data_q;
   frame_type_e          frame_type_q;
   logic                 frame_valid_q;

   // ------------------------------------------------------------------
   // Derived per-cycle strobes
   // ------------------------------------------------------------------
   logic                 link_on;
   logic                 leaving_off;
   logic                 hb_pending_eff;
   logic                 hb_wrap;
   logic                 load;
   logic                 data_offer;

   // Arbitration result
   frame_type_e          sel_type;
   logic [DATA_W-1:0]    sel_data;
   logic                 take_ctrl;
   logic                 take_hb;

   // Mode register: remembers the previous cycle's mode so that leaving OFF
   // can be detected.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mode_q <= MODE_OFF;
      end else begin
         // NOTE: clocked state always uses non-blocking assignments so every
         // register samples the pre-edge values of every other register.
         mode_q <= mode_d;
      end
   end

   // Next mode is a pure decode of the enables; any transition takes one cycle.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // which guarantees no latch is inferred on an uncovered path.
      mode_d = MODE_OFF;
      if (tx_link_enable_i) begin
         mode_d = tx_data_enable_i ? MODE_DATA : MODE_TRAIN;
      end
   end

   assign link_on     = (mode_d != MODE_OFF);
   assign data_offer  = (mode_d == MODE_DATA) && user_tvalid_i;

   // Coming out of OFF counts as an already-pending heartbeat. The first slot
   // after enable then advertises rx_ready without waiting a full interval.
   assign leaving_off    = (mode_q == MODE_OFF) && link_on;
   assign hb_pending_eff = hb_pending_q || leaving_off;

   // A slot opens when the output register is empty or drains this cycle.
   assign load    = link_on && (!frame_valid_q || frame_ready_i);
   assign hb_wrap = link_on && (hb_cnt_q == HB_LAST);

   // Slot arbiter: fixed priority, with a fairness override so that a run of
   // control frames cannot starve waiting user data.
   always_comb begin
      sel_type  = FT_IDLE;
      sel_data  = '0;
      take_ctrl = 1'b0;
      take_hb   = 1'b0;

      if (last_ctrl_q && data_offer) begin
         sel_type = FT_DATA;
         sel_data = user_tdata_i;
      end else if (ctrl_req_i) begin
         sel_type      = FT_CTRL;
         sel_data[7:0] = ctrl_code_i;
         sel_data[8]   = rx_ready_i;
         take_ctrl     = 1'b1;
      end else if (hb_pending_eff) begin
         sel_type    = FT_CTRL;
         sel_data[8] = rx_ready_i;
         take_hb     = 1'b1;
      end else if (data_offer) begin
         sel_type = FT_DATA;
         sel_data = user_tdata_i;
      end else if (mode_d == MODE_TRAIN) begin
         sel_type = FT_TRAIN;
         sel_data = TRAIN_WORD;
      end else begin
         sel_type = FT_IDLE;
         sel_data = '0;
      end
   end

   // Handshakes only fire on a real slot. In OFF or in a stall, load is low,
   // so both stay low.
   assign user_tready_o = load && (sel_type == FT_DATA);
   assign ctrl_ack_o    = load && take_ctrl;

   // Heartbeat interval counter: free-running while the link is up, held at 0 in OFF.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hb_cnt_q <= '0;
      end else if (!link_on || hb_wrap) begin
         hb_cnt_q <= '0;
      end else begin
         hb_cnt_q <= hb_cnt_q + HB_CNT_W'(1);
      end
   end

   // Heartbeat request flag. It is a single bit, so a wrap while a heartbeat
   // is still owed does not queue a second one. A wrap in the same cycle as a
   // heartbeat load re-arms the flag.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hb_pending_q <= 1'b0;
      end else if (!link_on) begin
         hb_pending_q <= 1'b0;
      end else begin
         hb_pending_q <= (hb_pending_eff && !(load && take_hb)) || hb_wrap;
      end
   end

   // Fairness memory: records whether the most recently loaded frame was CTRL.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_ctrl_q <= 1'b0;
      end else if (!link_on) begin
         last_ctrl_q <= 1'b0;
      end else if (load) begin
         last_ctrl_q <= (sel_type == FT_CTRL);
      end
   end

   // Output frame register. It is written only on a slot. Dropping the link
   // aborts the in-flight frame even if downstream is stalled.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         frame_data_q  <= '0;
         frame_type_q  <= FT_IDLE;
         frame_valid_q <= 1'b0;
      end else if (!link_on) begin
         frame_valid_q <= 1'b0;
      end else if (load) begin
         frame_data_q  <= sel_data;
         frame_type_q  <= sel_type;
         frame_valid_q <= 1'b1;
      end
   end

   assign frame_data_o  = frame_data_q;
   assign frame_type_o  = frame_type_q;
   assign frame_valid_o = frame_valid_q;

endmodule

// File: tb/tb_qeciphy_tx_scheduler.sv
// Testbench for qeciphy_tx_scheduler (DATA_W=64, HB_INTERVAL=16).
// It applies a directed vector table for bring-up, streaming and the
// ctrl/heartbeat collision. Hand-written sequences cover backpressure, data
// disable and abort, and a randomized run follows. Every cycle is also
// compared against a slot-level reference model. In that model, heartbeats
// fall due whenever the time since link enable is a multiple of the interval.
`timescale 1ns/1ps
module tb_qeciphy_tx_scheduler;

   localparam int          DATA_W    = 64;
   localparam int          HB        = 16;
   localparam logic [63:0] TRAIN_PAT = 64'hBC50_BC50_BC50_BC50;
   localparam logic [1:0]  T_IDLE    = 2'b00;
   localparam logic [1:0]  T_TRAIN   = 2'b01;
   localparam logic [1:0]  T_CTRL    = 2'b10;
   localparam logic [1:0]  T_DATA    = 2'b11;
   localparam logic [63:0] HB_WORD   = 64'h100;   // heartbeat with rx_ready=1
   localparam int          NVEC      = 53;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        link_en, data_en, rx_ready;
   logic [63:0] tdata;
   logic        tvalid, tready;
   logic        ctrl_req, ctrl_ack;
   logic [7:0]  ctrl_code;
   logic [63:0] fdata;
   logic [1:0]  ftype;
   logic        fvalid, fready;

   always #5 clk = ~clk;

   qeciphy_tx_scheduler #(
      .DATA_W        (DATA_W),
      .HB_INTERVAL   (HB),
      .TRAIN_PATTERN (TRAIN_PAT)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .tx_link_enable_i (link_en),
      .tx_data_enable_i (data_en),
      .rx_ready_i       (rx_ready),
      .user_tdata_i     (tdata),
      .user_tvalid_i    (tvalid),
      .user_tready_o    (tready),
      .ctrl_req_i       (ctrl_req),
      .ctrl_code_i      (ctrl_code),
      .ctrl_ack_o       (ctrl_ack),
      .frame_data_o     (fdata),
      .frame_type_o     (ftype),
      .frame_valid_o    (fvalid),
      .frame_ready_i    (fready)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model (slot level)
   // ------------------------------------------------------------------
   bit          m_valid;
   logic [1:0]  m_type;
   logic [63:0] m_data;
   bit          m_last_ctrl;
   bit          m_owed;        // heartbeat due but not yet sent
   int          m_t_on;        // cycles since the link came up
   bit          exp_tready, exp_ack;
   logic        s_tready, s_ack;

   // Inputs must already be driven for this cycle. The task checks the
   // registered frame and the handshakes, advances the model, and returns at
   // the next falling edge.
   task automatic step();
      bit          due, hb_taken, want_data;
      logic [1:0]  k_type;
      logic [63:0] k_data;
      #1;
      s_tready = tready;
      s_ack    = ctrl_ack;
      check("model frame_valid", {63'd0, fvalid}, {63'd0, m_valid});
      if (m_valid) begin
         check("model frame_type", {62'd0, ftype}, {62'd0, m_type});
         check("model frame_data", fdata, m_data);
      end
      exp_tready = 1'b0;
      exp_ack    = 1'b0;
      if (!link_en) begin
         m_valid     = 1'b0;
         m_owed      = 1'b0;
         m_t_on      = 0;
         m_last_ctrl = 1'b0;
      end else begin
         due      = m_owed || (m_t_on % HB == 0);
         hb_taken = 1'b0;
         if (!m_valid || fready) begin
            want_data = data_en && tvalid;
            if (m_last_ctrl && want_data) begin
               k_type = T_DATA;  k_data = tdata;
            end else if (ctrl_req) begin
               k_type = T_CTRL;  k_data = {55'd0, rx_ready, ctrl_code};  exp_ack = 1'b1;
            end else if (due) begin
               k_type = T_CTRL;  k_data = {55'd0, rx_ready, 8'h00};      hb_taken = 1'b1;
            end else if (want_data) begin
               k_type = T_DATA;  k_data = tdata;
            end else if (!data_en) begin
               k_type = T_TRAIN; k_data = TRAIN_PAT;
            end else begin
               k_type = T_IDLE;  k_data = 64'd0;
            end
            exp_tready  = (k_type == T_DATA);
            m_last_ctrl = (k_type == T_CTRL);
            m_valid     = 1'b1;
            m_type      = k_type;
            m_data      = k_data;
         end
         m_owed = due && !hb_taken;
         m_t_on++;
      end
      check("model user_tready", {63'd0, s_tready}, {63'd0, exp_tready});
      check("model ctrl_ack", {63'd0, s_ack}, {63'd0, exp_ack});
      @(posedge clk);
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------
   typedef struct {
      bit          link, den, tvalid, creq;
      logic [63:0] tdata;
      logic [7:0]  code;
      bit          e_tready, e_ack, e_valid;
      logic [1:0]  e_type;
      logic [63:0] e_data;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic vec_t mk(input bit link, input bit den, input bit tv, input bit creq,
                               input logic [63:0] td, input logic [7:0] code,
                               input bit e_tready, input bit e_ack, input bit e_valid,
                               input logic [1:0] e_type, input logic [63:0] e_data);
      vec_t v;
      v.link = link;  v.den = den;  v.tvalid = tv;  v.creq = creq;
      v.tdata = td;   v.code = code;
      v.e_tready = e_tready;  v.e_ack = e_ack;  v.e_valid = e_valid;
      v.e_type = e_type;      v.e_data = e_data;
      return v;
   endfunction

   int          beat;
   int          t;
   logic [63:0] beat_w;

   initial begin
      // Fill the table. Row i covers link-up cycle i-1. Heartbeats fall at
      // 0, 16, 32 and 49. The 48 slot is displaced one cycle by fairness
      // after the 0x5A ctrl frame, which is requested at cycle 47.
      vecs[0] = mk(0,0,0,0, 64'd0, 8'h00, 0,0,0, T_IDLE, 64'd0);
      vecs[1] = mk(1,0,0,0, 64'd0, 8'h00, 0,0,1, T_CTRL, HB_WORD);
      for (int i = 2; i <= 16; i++)
         vecs[i] = mk(1,0,0,0, 64'd0, 8'h00, 0,0,1, T_TRAIN, TRAIN_PAT);
      vecs[17] = mk(1,0,0,0, 64'd0, 8'h00, 0,0,1, T_CTRL, HB_WORD);
      beat = 1;
      for (int i = 18; i < NVEC; i++) begin
         t = i - 1;
         beat_w = 64'(beat);
         if (i == 48)
            vecs[i] = mk(1,1,1,1, beat_w, 8'h5A, 0,1,1, T_CTRL, 64'h15A);
         else if (t == 32 || t == 49)
            vecs[i] = mk(1,1,1,0, beat_w, 8'h00, 0,0,1, T_CTRL, HB_WORD);
         else begin
            vecs[i] = mk(1,1,1,0, beat_w, 8'h00, 1,0,1, T_DATA, beat_w);
            beat++;
         end
      end

      // Reset
      m_valid = 0; m_type = 0; m_data = 0; m_last_ctrl = 0; m_owed = 0; m_t_on = 0;
      rst_n = 1'b0;  link_en = 0;  data_en = 0;  rx_ready = 1;
      tdata = 0;  tvalid = 0;  ctrl_req = 0;  ctrl_code = 8'h00;  fready = 1;
      repeat (3) @(negedge clk);
      check("reset frame_valid", {63'd0, fvalid}, 64'd0);
      check("reset frame_type", {62'd0, ftype}, 64'd0);
      check("reset frame_data", fdata, 64'd0);
      check("reset user_tready", {63'd0, tready}, 64'd0);
      check("reset ctrl_ack", {63'd0, ctrl_ack}, 64'd0);
      rst_n = 1'b1;

      // Apply the table
      beat = 1;
      for (int i = 0; i < NVEC; i++) begin
         link_en = vecs[i].link;  data_en = vecs[i].den;  tvalid = vecs[i].tvalid;
         ctrl_req = vecs[i].creq; tdata = vecs[i].tdata;  ctrl_code = vecs[i].code;
         fready = 1'b1;  rx_ready = 1'b1;
         step();
         check($sformatf("vec%0d tready", i), {63'd0, s_tready}, {63'd0, vecs[i].e_tready});
         check($sformatf("vec%0d ack", i), {63'd0, s_ack}, {63'd0, vecs[i].e_ack});
         check($sformatf("vec%0d valid", i), {63'd0, fvalid}, {63'd0, vecs[i].e_valid});
         check($sformatf("vec%0d type", i), {62'd0, ftype}, {62'd0, vecs[i].e_type});
         check($sformatf("vec%0d data", i), fdata, vecs[i].e_data);
         if (vecs[i].e_tready) beat++;
      end
      ctrl_req = 1'b0;

      // Backpressure: five stalled cycles mid-stream, then resume.
      for (int k = 0; k < 5; k++) begin
         tvalid = 1'b1;  tdata = 64'(beat);  fready = 1'b0;
         step();
         check("stall tready", {63'd0, s_tready}, 64'd0);
         check("stall ack", {63'd0, s_ack}, 64'd0);
         check("stall valid", {63'd0, fvalid}, 64'd1);
         check("stall type", {62'd0, ftype}, {62'd0, T_DATA});
         check("stall data", fdata, 64'(beat - 1));
      end
      fready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tdata = 64'(beat);
         step();
         check("resume tready", {63'd0, s_tready}, 64'd1);
         check("resume type", {62'd0, ftype}, {62'd0, T_DATA});
         check("resume data", fdata, 64'(beat));
         beat++;
      end

      // Data disable at link-up cycle 60. The heartbeat stays on schedule at 64.
      data_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         t = 60 + k;
         step();
         check("disable tready", {63'd0, s_tready}, 64'd0);
         check("disable type", {62'd0, ftype}, {62'd0, (t == 64) ? T_CTRL : T_TRAIN});
         check("disable data", fdata, (t == 64) ? HB_WORD : TRAIN_PAT);
      end

      // Abort: stall a frame, then drop the link.
      fready = 1'b0;
      step();
      check("pre-abort valid", {63'd0, fvalid}, 64'd1);
      link_en = 1'b0;
      step();
      check("abort valid", {63'd0, fvalid}, 64'd0);
      repeat (2) step();
      link_en = 1'b1;  fready = 1'b1;  rx_ready = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         step();
         check("reenable type", {62'd0, ftype},
               {62'd0, (k == 0 || k == 16) ? T_CTRL : T_TRAIN});
         check("reenable data", fdata, (k == 0 || k == 16) ? 64'd0 : TRAIN_PAT);
      end

      // Randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         if (exp_ack) ctrl_req = 1'b0;
         if (link_en) begin
            if ($urandom_range(99) < 2) link_en = 1'b0;
         end else if ($urandom_range(99) < 30) begin
            link_en = 1'b1;
         end
         if ($urandom_range(99) < 5) data_en = ~data_en;
         fready   = ($urandom_range(3) != 0);
         tvalid   = ($urandom_range(9) < 7);
         tdata    = {$urandom, $urandom};
         rx_ready = $urandom_range(1);
         if (!ctrl_req && $urandom_range(19) == 0) begin
            ctrl_req  = 1'b1;
            ctrl_code = 8'($urandom_range(255, 1));
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
